// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART byte-to-frame receiver.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one write port, combinational read.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Store one payload byte per write strobe; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser: SOF, LEN, payload, XOR checksum; releases payload on a
// valid/ready stream only after the checksum matches.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [7:0]  SOF         = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int unsigned PW = width_of(MAX_LEN);
  localparam int unsigned LW = width_of(MAX_LEN + 1);
  localparam int unsigned GW = width_of(TIMEOUT_CYC);

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CYC - 1);

  state_t         state, state_n;
  logic [LW-1:0]  len, len_m1;
  logic [7:0]     chk_acc;
  logic [PW-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
  logic [GW-1:0]  gap_cnt, gap_n;
  logic [7:0]     rd_data;
  logic           wr_en, load_len, ok_pulse, err_pulse, counting, tmo;
  logic [1:0]     code_n;

  assign len_m1 = len - LW'(1);

  // Buffer is read at the pointer of the byte presented next cycle so m_data
  // can be registered without losing one-byte-per-cycle throughput.
  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_addr (rd_ptr_n),
    .rd_data (rd_data)
  );

  // Parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state decode, datapath controls and inter-byte timeout.
  always_comb begin
    state_n   = state;
    wr_en     = 1'b0;
    load_len  = 1'b0;
    ok_pulse  = 1'b0;
    err_pulse = 1'b0;
    code_n    = err_code;
    rd_ptr_n  = rd_ptr;
    counting  = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    tmo       = counting && !rx_strobe && (gap_cnt == GAP_LAST);

    case (state)
      ST_IDLE: begin
        if (rx_strobe && rx_data == SOF) state_n = ST_LEN;
      end
      ST_LEN: begin
        if (rx_strobe) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            err_pulse = 1'b1;
            code_n    = ERR_LEN;
            state_n   = ST_IDLE;
          end else begin
            load_len = 1'b1;
            state_n  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_strobe) begin
          wr_en = 1'b1;
          if (LW'(wr_ptr) == len_m1) state_n = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_strobe) begin
          if (rx_data == chk_acc) begin
            ok_pulse = 1'b1;
            rd_ptr_n = '0;
            state_n  = ST_DRAIN;
          end else begin
            err_pulse = 1'b1;
            code_n    = ERR_CHK;
            state_n   = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          if (m_last) state_n = ST_IDLE;
          else        rd_ptr_n = rd_ptr + PW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (tmo) begin
      err_pulse = 1'b1;
      code_n    = ERR_TMO;
      state_n   = ST_IDLE;
    end

    gap_n = (counting && !rx_strobe && !tmo) ? gap_cnt + GW'(1) : '0;
  end

  // Datapath registers and registered stream/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len       <= '0;
      chk_acc   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      gap_cnt   <= '0;
      drop_cnt  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
    end else begin
      gap_cnt <= gap_n;
      rd_ptr  <= rd_ptr_n;

      if (load_len) begin
        len     <= rx_data[LW-1:0];
        chk_acc <= rx_data;
        wr_ptr  <= '0;
      end else if (wr_en) begin
        chk_acc <= chk_acc ^ rx_data;
        wr_ptr  <= wr_ptr + PW'(1);
      end

      if (state == ST_DRAIN && rx_strobe && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      frame_ok  <= ok_pulse;
      frame_err <= err_pulse;
      if (err_pulse) err_code <= code_n;

      m_valid <= (state_n == ST_DRAIN);
      busy    <= (state_n != ST_IDLE);
      if (state_n == ST_DRAIN) begin
        m_data <= rd_data;
        m_last <= (LW'(rd_ptr_n) == len_m1);
      end else begin
        m_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: expected beats/events queued at stimulus time.
module tb_uart_frame_rx;
  import uart_frame_pkg::*;

  localparam int MAXL = 16;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strobe = 1'b0;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, frame_ok, frame_err, busy;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .MAX_LEN     (MAXL),
    .TIMEOUT_CYC (TMO),
    .SOF         (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Scoreboard: {last,data} per beat; events 4 = frame_ok, 1..3 = frame_err code.
  logic [8:0] exp_q [$];
  int         ev_q  [$];
  logic [7:0] pl    [256];
  int         rdy_mode = 0;

  // m_ready: 0 = always ready, 1 = toggling, 2 = stalled.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       m_ready = !m_ready;
        2:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Output monitor.
  logic       stall_prev = 1'b0;
  logic [8:0] held = '0;
  int         obs;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && m_valid) check_eq("hold_stable", 32'({m_last, m_data}), 32'(held));
      if (m_valid && m_ready) begin
        check_eq("spurious_beat", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("beat", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
      end
      stall_prev = m_valid && !m_ready;
      held       = {m_last, m_data};
      if (frame_ok || frame_err) begin
        obs = (frame_ok && frame_err) ? 7 : (frame_ok ? 4 : int'(err_code));
        check_eq("spurious_event", 32'(ev_q.size() > 0), 32'd1);
        if (ev_q.size() > 0) check_eq("event", 32'(obs), 32'(ev_q.pop_front()));
        if (frame_ok) check_eq("ok_with_valid", 32'(m_valid), 32'd1);
      end
    end
  end

  // Strobe a byte sampled 'edges' rising edges after the previous strobe.
  task automatic pulse_after(input int edges, input logic [7:0] b);
    repeat (edges - 1) @(posedge clk);
    #1 rx_data = b; rx_strobe = 1'b1;
    @(posedge clk);
    #1 rx_strobe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse_after(2, b);
  endtask

  task automatic send_frame(input int n, input bit good);
    logic [7:0] c;
    c = 8'(n);
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      send_byte(pl[i]);
      c = c ^ pl[i];
    end
    if (good) begin
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), pl[i]});
      ev_q.push_back(4);
      send_byte(c);
    end else begin
      ev_q.push_back(int'(ERR_CHK));
      send_byte(c ^ 8'h5A);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && ev_q.size() == 0 && exp_q.size() == 0) break;
    end
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_events"}, 32'(ev_q.size()), 32'd0);
    check_eq({tag, "_beats"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic count_valid(input int n);
    int cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_valid) cnt++;
      else if (cnt > 0) break;
    end
    check_eq("beat_cycles", 32'(cnt), 32'(n));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_m_valid"},   32'(m_valid),   32'd0);
    check_eq({tag, "_m_last"},    32'(m_last),    32'd0);
    check_eq({tag, "_m_data"},    32'(m_data),    32'd0);
    check_eq({tag, "_frame_ok"},  32'(frame_ok),  32'd0);
    check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check_eq({tag, "_err_code"},  32'(err_code),  32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    rst = 1'b0;

    // Good 3-byte frame, checksum 03.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(3, 1'b1);
    count_valid(3);
    wait_idle("good3");

    // Bad checksum: A5 02 AA 55 00.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55);
    ev_q.push_back(int'(ERR_CHK));
    send_byte(8'h00);
    wait_idle("badchk");
    check_eq("err_code_chk", 32'(err_code), 32'(ERR_CHK));

    // Bad LEN: zero and MAX_LEN+1.
    send_byte(8'hA5); ev_q.push_back(int'(ERR_LEN)); send_byte(8'h00);
    wait_idle("len0");
    send_byte(8'hA5); ev_q.push_back(int'(ERR_LEN)); send_byte(8'h11);
    wait_idle("len17");
    check_eq("err_code_len", 32'(err_code), 32'(ERR_LEN));

    // Good frame after errors, then maximum-length frame.
    pl[0] = 8'h5C; pl[1] = 8'h00;
    send_frame(2, 1'b1);
    wait_idle("after_err");
    for (int i = 0; i < MAXL; i++) pl[i] = 8'($urandom);
    send_frame(MAXL, 1'b1);
    count_valid(MAXL);
    wait_idle("maxlen");

    // Timeout after A5 02 11.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    ev_q.push_back(int'(ERR_TMO));
    repeat (TMO + 4) @(posedge clk);
    wait_idle("tmo");
    check_eq("err_code_tmo", 32'(err_code), 32'(ERR_TMO));

    // Strobe landing on the expiry cycle continues the frame.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    pulse_after(TMO, 8'h22);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    ev_q.push_back(4);
    send_byte(8'h02 ^ 8'h11 ^ 8'h22);
    wait_idle("expiry");

    // Backpressure with toggling m_ready.
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) pl[i] = 8'(8'hC0 + i);
    send_frame(4, 1'b1);
    wait_idle("bp");
    rdy_mode = 0;

    // Bytes during DRAIN are dropped (including a SOF).
    rdy_mode = 2;
    pl[0] = 8'h7E; pl[1] = 8'h81;
    send_frame(2, 1'b1);
    send_byte(8'hA5); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    check_eq("drop_cnt", 32'(drop_cnt), 32'd3);
    check_eq("drain_busy", 32'(busy), 32'd1);
    rdy_mode = 0;
    wait_idle("drop");

    // Reset mid-payload.
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pl[0] = 8'h99; pl[1] = 8'h66; pl[2] = 8'h0F;
    send_frame(3, 1'b1);
    wait_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Byte-to-frame receiver sitting directly downstream of the UART receive path: it consumes the byte stream and one-cycle byte strobe produced by `uart_rx` and assembles framed packets. Frame format is SOF, LEN, LEN payload bytes, CHK. Payload is buffered internally and released on a valid/ready stream only after the checksum passes. Bad or stalled frames are discarded and reported.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum payload bytes per frame. Legal range is 1..255.
- `TIMEOUT_CYC`, 100000: maximum idle clocks allowed between bytes inside a frame.
- `SOF`, 8'hA5: start-of-frame byte.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: received byte, valid only when `rx_strobe`=1.
- `rx_strobe`, in, 1: one-cycle pulse per received byte (from `uart_rx` `rx_ready`).
- `m_data`, out, 8: payload byte.
- `m_valid`, out, 1: `m_data` is valid.
- `m_ready`, in, 1: consumer accepts the byte.
- `m_last`, out, 1: marks the final payload byte of the frame.
- `frame_ok`, out, 1: one-cycle pulse when a frame has passed its checksum.
- `frame_err`, out, 1: one-cycle pulse when a frame is discarded.
- `err_code`, out, 2: 01 = bad LEN, 10 = checksum, 11 = timeout. Held until the next `frame_err`.
- `busy`, out, 1: high in any state other than IDLE.
- `drop_cnt`, out, 8: saturating count of bytes dropped during DRAIN.

## Operation
- States: IDLE, LEN, PAYLOAD, CHK, DRAIN.
- IDLE:
  - strobe with `rx_data`==SOF -> LEN.
  - strobe with any other byte: ignored, not counted.
- LEN:
  - strobe with value 0 or value > MAX_LEN -> `frame_err`, `err_code`=01, -> IDLE.
  - otherwise latch `len`, seed `chk_acc`=LEN, clear `wr_ptr`, -> PAYLOAD.
- PAYLOAD:
  - each strobe writes buf[`wr_ptr`], `chk_acc` ^= byte, `wr_ptr`++.
  - after the LEN-th byte -> CHK.
- CHK:
  - strobe with byte == `chk_acc` -> `frame_ok`, `rd_ptr`=0, -> DRAIN.
  - mismatch -> `frame_err`, `err_code`=10, -> IDLE.
- DRAIN:
  - `m_valid`=1, `m_data`=buf[`rd_ptr`], `m_last`=(`rd_ptr`==len-1).
  - on `m_valid`&`m_ready`, `rd_ptr`++.
  - handshake on the last byte -> IDLE.
- Bytes strobed during DRAIN are dropped; `drop_cnt` increments and saturates at 255. A SOF arriving in DRAIN is also dropped.
- Timeout:
  - in LEN, PAYLOAD and CHK, `gap_cnt` increments each cycle without a strobe and clears on a strobe.
  - `gap_cnt`==TIMEOUT_CYC-1 with no strobe -> `frame_err`, `err_code`=11, -> IDLE.
  - a strobe in the same cycle wins over the timeout.
  - `gap_cnt` is held at 0 in IDLE and DRAIN.
- Width rules:
  - `wr_ptr`/`rd_ptr` are $clog2(MAX_LEN) bits; `len` and `gap_cnt` are sized to fit their maximum values.
  - checksum is a pure 8-bit XOR.
- Reset values: `m_valid`=0, `m_last`=0, `m_data`=0, `frame_ok`=0, `frame_err`=0, `err_code`=00, `busy`=0, `drop_cnt`=0, state=IDLE. Buffer contents are not reset.
- Reset mid-frame or mid-DRAIN aborts immediately. No error pulse is emitted and the partial frame is lost.

## Timing
- All outputs are registered.
- `frame_ok` and first `m_valid` both rise in the cycle after the CHK strobe.
- `frame_err` is asserted in the cycle after the offending strobe, or the cycle after the timeout compare.
- Throughput: one payload byte per cycle while `m_ready`=1.
- `m_data`/`m_last` are stable while `m_valid`&!`m_ready`.
- After the last handshake, `m_valid`=0 and `busy`=0 on the next cycle; a SOF strobe in that cycle is accepted.
- Input strobe rate assumption: one strobe per ≥2 cycles (UART rate); back-to-back strobes still parse correctly.

## Structure
- Package `uart_frame_pkg` holds: state enum, `ERR_LEN`/`ERR_CHK`/`ERR_TMO` codes, default `SOF`.
- Sub-module `uart_frame_buf`: MAX_LEN×8 register file with 1 write port and 1 read port; read is combinational from `rd_ptr`, registered into `m_data` by the parent.
- Top-level parser FSM, counters and stream output live in `uart_frame_rx`.

## Test plan
- Good frame: A5 03 11 22 33 03 (CHK = 03^11^22^33 = 03), `m_ready`=1 -> `frame_ok` pulse; `m_data` 11,22,33 on consecutive cycles, `m_last` on 33.
- Bad checksum: A5 02 AA 55 00 -> `frame_err`, `err_code`=10, `m_valid` never asserted, `busy` drops.
- Bad LEN:
  - A5 00 -> `err_code`=01.
  - A5 11 (17 > MAX_LEN=16) -> `err_code`=01.
  - subsequent good frame still accepted.
- Timeout: A5 02 11, then no strobe for TIMEOUT_CYC cycles -> `frame_err`, `err_code`=11; a strobe on the exact expiry cycle instead continues the frame.
- Backpressure and drop:
  - good 4-byte frame with `m_ready` toggling 1/0 -> data held stable, all 4 bytes delivered in order.
  - 3 bytes strobed during DRAIN -> `drop_cnt`=3.
- Reset asserted mid-PAYLOAD -> all outputs reach reset values immediately, no `frame_err`; next frame parses normally.
